// File: rtl/dot_trail_gen_pkg.sv
// dot_trail_gen_pkg: shared constants, FSM encoding and the bounce step for the dot demo
package dot_trail_gen_pkg;
  localparam int BMP_W = 7;
  localparam int ADDR_W = 2 * BMP_W;
  localparam logic [BMP_W-1:0] BMP_MAX = '1;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;
  localparam logic [2:0] BG_RGB = 3'b110;
  localparam logic [9:0] REFR_Y = 10'd481;
  typedef enum logic [1:0] {CLR = 2'd0, IDLE = 2'd1, RUN = 2'd2} state_t;
  // Returns {neg, pos}: one-pixel move that reflects off the bitmap edges.
  function automatic logic [BMP_W:0] axis_step(input logic neg, input logic [BMP_W-1:0] p);
    return (!neg && p == BMP_MAX) ? {1'b1, BMP_MAX - 1'b1} :
           (neg && p == '0)       ? {1'b0, BMP_W'(1)} :
                                    {neg, neg ? p - 1'b1 : p + 1'b1};
  endfunction
endpackage

// File: rtl/dot_vram.sv
// dot_vram: simple dual-port read-first synchronous RAM, contents not reset
module dot_vram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] dout_b
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[addr_a] <= din_a;
    dout_b <= mem[addr_b];
  end
endmodule

// File: rtl/dot_trail_gen.sv
// dot_trail_gen: bitmap generator with a bouncing dot leaving a trail in video RAM
module dot_trail_gen
  import dot_trail_gen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic [2:0] sw,
  input  logic       video_on,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [2:0] bit_rgb
);
  state_t state_q, state_d;
  logic [1:0] btn_q;
  logic refr_q, refr_c, refr_tick, start_e, clr_e;
  logic [BMP_W-1:0] rx_q, ry_q, x_q, x_d, y_q, y_d;
  logic dxn_q, dxn_d, dyn_q, dyn_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d, waddr;
  logic we, video_q, in_bmp_q, in_bmp;
  logic [2:0] wdata, rdata;
  always_comb begin
    start_e = btn[0] & ~btn_q[0];
    clr_e = btn[1] & ~btn_q[1];
    refr_c = (pix_y == REFR_Y) && (pix_x == '0);
    refr_tick = refr_c && !refr_q;
    in_bmp = (pix_x[9:BMP_W] == '0) && (pix_y[9:BMP_W] == '0);
    state_d = state_q;
    clr_addr_d = clr_addr_q;
    x_d = x_q;
    y_d = y_q;
    dxn_d = dxn_q;
    dyn_d = dyn_q;
    we = 1'b0;
    waddr = {y_q, x_q};
    wdata = sw;
    // Clear wins over everything, including a coincident start edge.
    if (clr_e) begin
      state_d = CLR;
      clr_addr_d = '0;
    end else if (state_q == CLR) begin
      we = 1'b1;
      waddr = clr_addr_q;
      wdata = 3'b000;
      clr_addr_d = clr_addr_q + 1'b1;
      state_d = (clr_addr_q == CLR_LAST) ? IDLE : CLR;
    end else if (start_e) begin
      x_d = rx_q;
      y_d = ry_q;
      dxn_d = 1'b0;
      dyn_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && refr_tick) begin
      we = 1'b1;
      {dxn_d, x_d} = axis_step(dxn_q, x_q);
      {dyn_d, y_d} = axis_step(dyn_q, y_q);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR;
      clr_addr_q <= '0;
      btn_q <= '0;
      refr_q <= 1'b0;
      rx_q <= '0;
      ry_q <= '0;
      x_q <= '0;
      y_q <= '0;
      dxn_q <= 1'b0;
      dyn_q <= 1'b0;
      video_q <= 1'b0;
      in_bmp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      btn_q <= btn;
      refr_q <= refr_c;
      rx_q <= rx_q + 1'b1;
      ry_q <= (rx_q == BMP_MAX) ? ry_q + 1'b1 : ry_q;
      x_q <= x_d;
      y_q <= y_d;
      dxn_q <= dxn_d;
      dyn_q <= dyn_d;
      video_q <= video_on;
      in_bmp_q <= in_bmp;
    end
  end
  dot_vram #(.ADDR_W(ADDR_W), .DATA_W(3)) u_vram (
    .clk(clk),
    .we(we),
    .addr_a(waddr),
    .din_a(wdata),
    .addr_b({pix_y[BMP_W-1:0], pix_x[BMP_W-1:0]}),
    .dout_b(rdata)
  );
  assign bit_rgb = !video_q ? 3'b000 : in_bmp_q ? rdata : BG_RGB;
endmodule

// File: tb/tb_dot_trail_gen.sv
// tb_dot_trail_gen: directed scoreboard bench for the bouncing-dot bitmap generator
module tb_dot_trail_gen;
  logic clk = 1'b0, reset = 1'b1, video_on = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [2:0] sw = 3'b000, bit_rgb;
  logic [9:0] pix_x = '0, pix_y = '0;
  typedef struct {logic [9:0] x, y; logic [2:0] e;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic pend = 1'b0;
  logic [13:0] m_c;
  logic [6:0] mx, my;
  logic mxn, myn;

  dot_trail_gen dut (.clk(clk), .reset(reset), .btn(btn), .sw(sw), .video_on(video_on),
                     .pix_x(pix_x), .pix_y(pix_y), .bit_rgb(bit_rgb));

  always #5 clk = ~clk;
  // Expected seed counters: {ry,rx} count clocks since reset, wrapping at 16384.
  always @(posedge clk) m_c <= reset ? 14'd0 : m_c + 14'd1;

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (bit_rgb === e.e) else begin
      errors++;
      $error("FAIL rd x=%0d y=%0d got %b exp %b", e.x, e.y, bit_rgb, e.e);
    end
  endtask

  task automatic flush();
    if (pend) check_out();
    pend = 1'b0;
  endtask

  // Drive one pixel for one clock; its colour is checked at the next negedge.
  task automatic px(input int x, input int y, input logic v, input logic [2:0] e);
    exp_t t;
    if (pend) check_out();
    pix_x = 10'(x);
    pix_y = 10'(y);
    video_on = v;
    t.x = 10'(x);
    t.y = 10'(y);
    t.e = e;
    sb.push_back(t);
    pend = 1'b1;
    @(negedge clk);
  endtask

  task automatic mstep(inout logic n, inout logic [6:0] p);
    if (!n && p == 7'd127) begin n = 1'b1; p = 7'd126; end
    else if (n && p == 7'd0) begin n = 1'b0; p = 7'd1; end
    else if (n) p = p - 7'd1;
    else p = p + 7'd1;
  endtask

  // One refresh tick, then read back the pixel the dot just painted.
  task automatic tick(input logic [2:0] c);
    logic [6:0] ox, oy;
    flush();
    sw = c;
    pix_x = 10'd0;
    pix_y = 10'd481;
    @(negedge clk);
    ox = mx;
    oy = my;
    mstep(mxn, mx);
    mstep(myn, my);
    px(ox, oy, 1'b1, c);
  endtask

  task automatic press();
    flush();
    btn[0] = 1'b1;
    mx = m_c[6:0];
    my = m_c[13:7];
    mxn = 1'b0;
    myn = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_btn();
    flush();
    btn = 2'b00;
    @(negedge clk);
  endtask

  task automatic wait_seed(input logic [13:0] t);
    flush();
    for (int i = 0; i < 20000 && m_c != t; i++) @(negedge clk);
    checks++;
    assert (m_c === t) else begin
      errors++;
      $error("FAIL seed_wait got %0d exp %0d", m_c, t);
    end
  endtask

  initial begin
    pix_x = 10'd5;
    pix_y = 10'd5;
    video_on = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    assert (bit_rgb === 3'b000) else begin
      errors++;
      $error("FAIL reset_rgb got %b exp %b", bit_rgb, 3'b000);
    end
    reset = 1'b0;
    repeat (16390) @(negedge clk);
    px(5, 9, 1'b1, 3'b000);
    px(200, 50, 1'b1, 3'b110);
    px(200, 50, 1'b0, 3'b000);
    px(128, 5, 1'b1, 3'b110);
    px(5, 128, 1'b1, 3'b110);
    px(127, 127, 1'b1, 3'b000);
    px(0, 0, 1'b1, 3'b000);
    // Seed (x=10,y=20): trail at (10,20),(11,21),(12,22), dot then at (13,23).
    wait_seed({7'd20, 7'd10});
    press();
    release_btn();
    tick(3'b011);
    tick(3'b011);
    tick(3'b011);
    tick(3'b111);
    px(10, 20, 1'b1, 3'b011);
    px(11, 21, 1'b1, 3'b011);
    px(10, 20, 1'b0, 3'b000);
    px(12, 22, 1'b1, 3'b011);
    // Seed (126,126): reflect at 127, travel down the diagonal, reflect at 0.
    wait_seed({7'd126, 7'd126});
    press();
    release_btn();
    for (int k = 0; k < 131; k++) tick(3'(k % 7 + 1));
    // Held start button: one reload only, then a fresh press reloads again.
    press();
    for (int k = 0; k < 5; k++) tick(3'b101);
    release_btn();
    repeat (3) @(negedge clk);
    press();
    release_btn();
    tick(3'b010);
    tick(3'b100);
    // Clear and start together: clear wins, sweep finishes in IDLE.
    flush();
    btn = 2'b11;
    @(negedge clk);
    btn = 2'b00;
    repeat (16400) @(negedge clk);
    sw = 3'b111;
    pix_x = 10'd0;
    pix_y = 10'd481;
    @(negedge clk);
    for (int y = 0; y < 128; y++)
      for (int x = 0; x < 128; x++) px(x, y, 1'b1, 3'b000);
    px(300, 10, 1'b1, 3'b110);
    px(640, 479, 1'b0, 3'b000);
    flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
